// File: rtl/ysyx_24100005_ifu.sv
// Instruction-fetch unit: owns the PC, fetches over a valid/ready handshake with
// memory, and holds each instruction for decode. Redirects kill in-flight fetches.
module ysyx_24100005_ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign
);

  // state | meaning
  // IDLE  | one-cycle gap after reset before the first request
  // REQ   | request for pc presented to memory
  // WAIT  | request accepted, waiting for its response
  // OUT   | instruction held for decode
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n, redir_pc;
  logic            kill, kill_n, latch, misalign_n;
  logic [ILEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;

  assign redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign misalign_n = misalign | (redirect_valid & (|redirect_pc[1:0]));

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == OUT) & ~redirect_valid;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect_valid) pc_n = redir_pc;
      end
      REQ: begin
        if (imem_req_ready) begin
          state_n = WAIT;
          // The old-PC request is already gone; its response must be dropped.
          if (redirect_valid) begin
            pc_n   = redir_pc;
            kill_n = 1'b1;
          end
        end else if (redirect_valid) begin
          pc_n = redir_pc;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_n = REQ;
          kill_n  = 1'b0;
          if (redirect_valid) begin
            pc_n = redir_pc;
          end else if (!kill) begin
            latch   = 1'b1;
            state_n = OUT;
          end
        end else if (redirect_valid) begin
          pc_n   = redir_pc;
          kill_n = 1'b1;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          pc_n    = redir_pc;
          state_n = REQ;
        end else if (inst_ready) begin
          pc_n    = pc + XLEN'(4);
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      misalign  <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      kill     <= kill_n;
      misalign <= misalign_n;
      if (latch) begin
        inst_q    <= imem_resp_data;
        inst_pc_q <= pc;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Scoreboard bench for the fetch unit: two instances (normal and wrap-around reset PC)
// share one memory model; the monitor checks accepted requests and consumed instructions.
module tb_ysyx_24100005_ifu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, sel = 1'b0;
  logic        imem_req_ready = 1'b1, imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_ready = 1'b1, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        a_req_valid, a_inst_valid, a_misalign;
  logic [31:0] a_req_addr, a_inst, a_inst_pc;
  logic        b_req_valid, b_inst_valid, b_misalign;
  logic [31:0] b_req_addr, b_inst, b_inst_pc;

  logic        m_req_valid, m_inst_valid, m_misalign;
  logic [31:0] m_req_addr, m_inst, m_inst_pc;
  assign m_req_valid  = sel ? b_req_valid  : a_req_valid;
  assign m_inst_valid = sel ? b_inst_valid : a_inst_valid;
  assign m_misalign   = sel ? b_misalign   : a_misalign;
  assign m_req_addr   = sel ? b_req_addr   : a_req_addr;
  assign m_inst       = sel ? b_inst       : a_inst;
  assign m_inst_pc    = sel ? b_inst_pc    : a_inst_pc;

  ysyx_24100005_ifu #(.XLEN(32), .ILEN(32), .RESET_PC(32'h8000_0000)) dut_a (
    .clk(clk), .rst(rst),
    .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(a_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(a_inst_valid), .inst_ready(inst_ready), .inst(a_inst), .inst_pc(a_inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign(a_misalign)
  );

  ysyx_24100005_ifu #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(b_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(b_inst_valid), .inst_ready(inst_ready), .inst(b_inst), .inst_pc(b_inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign(b_misalign)
  );

  typedef struct {logic [31:0] pc; logic [31:0] data;} inst_t;
  logic [31:0] exp_addr[$];
  inst_t       exp_inst[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_cyc = 0;
  bit chk_period = 0, have_last = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: one outstanding request, response resp_delay cycles after acceptance.
  int          resp_delay = 1, cnt = 0;
  bit          pend = 0;
  logic [31:0] pend_addr = '0;
  always @(negedge clk) begin
    #1;
    imem_resp_valid = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_data(pend_addr);
        pend = 0;
      end else cnt--;
    end
    if (!rst && m_req_valid && imem_req_ready) begin
      pend = 1; cnt = resp_delay - 1; pend_addr = m_req_addr;
    end
  end

  // Monitor: values sampled here are the ones the next posedge acts on.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst && m_req_valid && imem_req_ready) begin
      if (exp_addr.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_unexpected actual=%h required=none t=%0t", m_req_addr, $time);
      end else check("req_addr", m_req_addr, exp_addr.pop_front());
    end
    if (!rst && m_inst_valid && inst_ready) begin
      if (exp_inst.size() == 0) begin
        checks++; errors++;
        $display("FAIL inst_unexpected actual=%h/%h required=none t=%0t", m_inst_pc, m_inst, $time);
      end else begin
        inst_t e;
        e = exp_inst.pop_front();
        check("inst_pc", m_inst_pc, e.pc);
        check("inst_data", m_inst, e.data);
      end
      if (chk_period && have_last) check("inst_period", cyc - last_cyc, 3);
      last_cyc = cyc; have_last = 1;
    end
  end

  task automatic expect_fetch(input logic [31:0] a);
    inst_t e;
    e.pc = a; e.data = mem_data(a);
    exp_addr.push_back(a);
    exp_inst.push_back(e);
  endtask

  task automatic do_reset(input logic [31:0] rpc);
    rst = 1'b1; redirect_valid = 1'b0; inst_ready = 1'b1; imem_req_ready = 1'b1;
    resp_delay = 1; chk_period = 0; have_last = 0;
    exp_addr.delete(); exp_inst.delete();
    repeat (3) @(negedge clk);
    check("rst_req_valid", {31'b0, m_req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, m_inst_valid}, 32'd0);
    check("rst_misalign", {31'b0, m_misalign}, 32'd0);
    check("rst_addr", m_req_addr, rpc);
    check("rst_inst", m_inst, 32'd0);
    check("rst_inst_pc", m_inst_pc, 32'd0);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", {31'b0, m_req_valid}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_addr.size() != 0 || exp_inst.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    check("drain_left", exp_addr.size() + exp_inst.size(), 32'd0);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    while (!m_inst_valid && n < budget) begin
      @(negedge clk); n++;
    end
    ok = m_inst_valid;
    check("wait_inst_valid", {31'b0, m_inst_valid}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Free run: three sequential fetches, one every third cycle.
    sel = 1'b0;
    do_reset(32'h8000_0000);
    expect_fetch(32'h8000_0000); expect_fetch(32'h8000_0004); expect_fetch(32'h8000_0008);
    chk_period = 1;
    release_rst();
    wait_drain(60);

    // Decode stall for five cycles in OUT.
    do_reset(32'h8000_0000);
    exp_addr.push_back(32'h8000_0000);
    inst_ready = 1'b0;
    release_rst();
    wait_valid(30, ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        check("stall_valid", {31'b0, m_inst_valid}, 32'd1);
        check("stall_inst", m_inst, mem_data(32'h8000_0000));
        check("stall_inst_pc", m_inst_pc, 32'h8000_0000);
        check("stall_no_req", {31'b0, m_req_valid}, 32'd0);
      end
      begin
        inst_t e;
        e.pc = 32'h8000_0000; e.data = mem_data(32'h8000_0000);
        exp_inst.push_back(e);
      end
      expect_fetch(32'h8000_0004);
      inst_ready = 1'b1;
      @(negedge clk);
      check("after_stall_req", {31'b0, m_req_valid}, 32'd1);
      check("after_stall_addr", m_req_addr, 32'h8000_0004);
    end
    wait_drain(60);

    // Redirect in WAIT; the old response arrives a cycle later and is dropped.
    do_reset(32'h8000_0000);
    resp_delay = 2;
    exp_addr.push_back(32'h8000_0000);
    expect_fetch(32'h8000_0100);
    release_rst();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    #2 check("wait_redir_valid0", {31'b0, m_inst_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2 check("killed_resp_valid0", {31'b0, m_inst_valid}, 32'd0);
    @(negedge clk);
    check("post_kill_valid0", {31'b0, m_inst_valid}, 32'd0);
    check("post_kill_addr", m_req_addr, 32'h8000_0100);
    wait_drain(60);

    // Redirect and inst_ready together in OUT: redirect wins.
    do_reset(32'h8000_0000);
    exp_addr.push_back(32'h8000_0000);
    expect_fetch(32'h8000_0200);
    release_rst();
    wait_valid(30, ok);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    #1 check("out_redir_valid0", {31'b0, m_inst_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    check("out_redir_req", {31'b0, m_req_valid}, 32'd1);
    check("out_redir_addr", m_req_addr, 32'h8000_0200);
    wait_drain(60);

    // Misaligned redirect while REQ is back-pressured.
    do_reset(32'h8000_0000);
    expect_fetch(32'h8000_0100);
    imem_req_ready = 1'b0;
    release_rst();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    check("misalign_set", {31'b0, m_misalign}, 32'd1);
    check("misalign_addr", m_req_addr, 32'h8000_0100);
    wait_drain(60);
    check("misalign_sticky", {31'b0, m_misalign}, 32'd1);

    // Wrap-around instance: 0xFFFF_FFFC + 4 wraps to 0.
    sel = 1'b1;
    do_reset(32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC); expect_fetch(32'h0000_0000);
    release_rst();
    wait_drain(60);

    // Reset in WAIT; the late response lands in IDLE and is ignored.
    do_reset(32'hFFFF_FFFC);
    resp_delay = 2;
    exp_addr.push_back(32'hFFFF_FFFC);
    release_rst();
    @(negedge clk);
    rst = 1'b1;
    expect_fetch(32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0;
    #2 check("midrst_valid0", {31'b0, m_inst_valid}, 32'd0);
    check("midrst_idle_noreq", {31'b0, m_req_valid}, 32'd0);
    @(negedge clk);
    check("midrst_req", {31'b0, m_req_valid}, 32'd1);
    check("midrst_addr", m_req_addr, 32'hFFFF_FFFC);
    wait_drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
